rr_mux_arbiter_4: RTL

// - Round-robin arbiter that shares one 4:1 single-bit multiplexed line between four requesters.
// - Each requester raises req[i] and drives its bit on in[i].
// - The block grants exactly one owner, drives the mux select for it and holds the grant until release.
// - Sits between the requesting agents and the shared output line; it is the sole driver of the select.
//

---
 rtl/rr_mux_arb_pkg.sv | 32 +++
 rtl/rr_priority_pick.sv | 15 +
 rtl/rr_mux_arbiter_4.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rr_mux_arb_pkg.sv
// rtl/rr_mux_arb_pkg.sv - shared types, sizes and round-robin pick function for rr_mux_arbiter_4
package rr_mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set bit of mask searching ptr+1, ptr+2, ptr+3, ptr (mod N_REQ):
    // rotate so ptr+1 lands at bit 0, take the lowest set bit, rotate back.
    function automatic logic [SEL_W-1:0] pick(input logic [N_REQ-1:0] mask,
                                              input logic [SEL_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [SEL_W:0]     sh;
        logic [N_REQ-1:0]   rot;
        logic [SEL_W-1:0]   enc;
        dbl = {mask, mask};
        sh  = {1'b0, ptr} + (SEL_W+1)'(1);
        rot = N_REQ'(dbl >> sh);
        enc = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                enc = SEL_W'(k);
            end
        end
        return ptr + enc + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotate / priority-encode / rotate-back picker
module rr_priority_pick
    import rr_mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // idx is only meaningful when any is high.
    assign idx = pick(mask, ptr);
    assign any = |mask;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - round-robin arbiter owning a 4:1 single-bit mux; optional ARB_TIMEOUT_EN preemption
module rr_mux_arbiter_4
    import rr_mux_arb_pkg::*;
#(
    parameter logic [SEL_W-1:0] RESET_PTR = 2'd3,
    parameter int               MAX_HOLD  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             o,
    output logic             expired
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             take;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    // gnt_q is zero while idle, so one mask serves both first arbitration and handoff.
    rr_priority_pick u_pick (
        .mask (req & ~gnt_q),
        .ptr  (ptr_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              expired_q, expired_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
`endif

    // Next-state: start, hand off, release or (optionally) preempt the grant.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        take    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    take = 1'b1;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    // Without a competitor the counter simply saturates here.
                    if (pick_any) begin
                        take      = 1'b1;
                        expired_d = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            gnt_d   = N_REQ'(1) << pick_idx;
            sel_d   = pick_idx;
            ptr_d   = pick_idx;
            valid_d = 1'b1;
            state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State registers; async reset clears an in-flight grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= RESET_PTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle preemption pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
        end
    end
    assign expired = expired_q;
`else
    assign expired = 1'b0;
`endif

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign o     = in[sel_q] & valid_q;

endmodule
